// File: rtl/dispatch_pkg.sv
// Shared types and sizes for the dispatch rename/status stage.
// Table entries track {pending, producer tag} per architectural register.
package dispatch_pkg;

  localparam int NUM_REGS = 32;
  localparam int TAG_W    = 6;
  localparam int IDX_W    = $clog2(NUM_REGS);

  typedef struct packed {
    logic             pending;
    logic [TAG_W-1:0] tag;
  } rst_entry_t;

  // WAIT: tag_in is valid this cycle. HAVE: tag parked in the staged register.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HAVE = 2'd2
  } alloc_state_e;

endpackage

// File: rtl/tag_alloc_ctrl.sv
// Keeps one free-list tag ready for the next rd allocation, pulling a
// replacement on every consume so back-to-back dispatches never stall.
module tag_alloc_ctrl
  import dispatch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             needs_tag,
  input  logic             tag_empty,
  input  logic [TAG_W-1:0] tag_in,
  output logic             disp_stall,
  output logic             consume,
  output logic             tag_pull,
  output logic [TAG_W-1:0] alloc_tag,
  output alloc_state_e     state_dbg
);

  alloc_state_e     state_q, state_d;
  logic [TAG_W-1:0] staged_q;

  // Handshake: a dispatch needing a tag is accepted (consume) exactly when
  // disp_stall is low; the free list answers a pull one cycle later on tag_in.
  always_comb begin
    disp_stall = needs_tag & (state_q == IDLE);
    consume    = needs_tag & ~disp_stall;
    tag_pull   = rst & ~tag_empty & ((state_q == IDLE) | consume);
    alloc_tag  = (state_q == WAIT) ? tag_in : staged_q;
    state_d    = state_q;
    case (state_q)
      IDLE: if (tag_pull) state_d = WAIT;
      WAIT: begin
        if (consume) state_d = tag_pull ? WAIT : IDLE;
        else         state_d = HAVE;
      end
      HAVE: if (consume) state_d = tag_pull ? WAIT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      staged_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == WAIT) && !consume) staged_q <= tag_in;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: rtl/register_status_table.sv
// Rename/status stage: per-register pending/tag table with CDB bypass on
// operand lookup and fresh tag allocation for rd from the free list.
module register_status_table
  import dispatch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             disp_valid,
  input  logic [IDX_W-1:0] disp_rs1,
  input  logic [IDX_W-1:0] disp_rs2,
  input  logic [IDX_W-1:0] disp_rd,
  input  logic             disp_rd_we,
  output logic             disp_stall,
  output logic             rs1_pending,
  output logic [TAG_W-1:0] rs1_tag,
  output logic             rs2_pending,
  output logic [TAG_W-1:0] rs2_tag,
  output logic [TAG_W-1:0] rd_tag,
  output logic             rd_tag_valid,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  output logic             tag_pull,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             tag_empty
);

  rst_entry_t       table_q [NUM_REGS];
  rst_entry_t       rs1_e, rs2_e;
  logic             needs_tag;
  logic             consume;
  logic [TAG_W-1:0] alloc_tag;
  alloc_state_e     alloc_state;

  assign needs_tag = disp_valid & disp_rd_we & (disp_rd != '0);

  tag_alloc_ctrl u_alloc (
    .clk        (clk),
    .rst        (rst),
    .needs_tag  (needs_tag),
    .tag_empty  (tag_empty),
    .tag_in     (tag_in),
    .disp_stall (disp_stall),
    .consume    (consume),
    .tag_pull   (tag_pull),
    .alloc_tag  (alloc_tag),
    .state_dbg  (alloc_state)
  );

  // Lookup reads the pre-dispatch table; a same-cycle CDB hit is forwarded.
  function automatic rst_entry_t lookup(input rst_entry_t e,
                                        input logic [IDX_W-1:0] idx,
                                        input logic cv,
                                        input logic [TAG_W-1:0] ct);
    rst_entry_t r;
    r = e;
    if (idx == '0) r = '0;
    else if (cv && r.pending && (r.tag == ct)) r.pending = 1'b0;
    return r;
  endfunction

  always_comb begin
    rs1_e       = lookup(table_q[disp_rs1], disp_rs1, cdb_valid, cdb_tag);
    rs2_e       = lookup(table_q[disp_rs2], disp_rs2, cdb_valid, cdb_tag);
    rs1_pending = rs1_e.pending;
    rs1_tag     = rs1_e.tag;
    rs2_pending = rs2_e.pending;
    rs2_tag     = rs2_e.tag;
  end

  // The dispatch write is issued after the CDB clears so it wins on a collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) table_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (cdb_valid && table_q[i].pending && (table_q[i].tag == cdb_tag))
          table_q[i].pending <= 1'b0;
      end
      if (consume) table_q[disp_rd] <= '{pending: 1'b1, tag: alloc_tag};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_tag       <= '0;
      rd_tag_valid <= 1'b0;
    end else begin
      rd_tag_valid <= consume;
      if (consume) rd_tag <= alloc_tag;
    end
  end

endmodule
